// File: rtl/counter_4_checker.sv
// counter_4_checker: locks onto a free-running up-counter stream and checks every sample is previous+1.
// Rev 1.0
`default_nettype none

module counter_4_checker #(
  parameter int WIDTH    = 4,
  parameter int ERR_W    = 8,
  parameter int CNT_W    = 16,
  parameter int LOCK_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] y,
  input  logic             clear,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count,
  output logic [WIDTH-1:0] expected
);

  localparam logic [3:0] C_LOCK_LEN = LOCK_LEN[3:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       run_q;
  logic             miss_q;
  logic             locked_q;
  logic             error_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] smp_cnt_q;
  logic [WIDTH-1:0] expected_q;

  logic             match;
  logic [3:0]       run_d;
  logic [ERR_W-1:0] err_cnt_d;
  logic [CNT_W-1:0] smp_cnt_d;
  logic [WIDTH-1:0] expected_d;

  always_comb begin
    match      = (y == expected_q);
    run_d      = run_q + 4'd1;
    err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
    smp_cnt_d  = (&smp_cnt_q) ? smp_cnt_q : smp_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    expected_d = y + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      run_q      <= 4'd0;
      miss_q     <= 1'b0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
      err_cnt_q  <= '0;
      smp_cnt_q  <= '0;
      expected_q <= '0;
    end else begin
      error_q <= 1'b0;
      if (clear) begin
        err_cnt_q <= '0;
        smp_cnt_q <= '0;
      end
      if (en) begin
        // Always resync to the observed value, whatever the state.
        expected_q <= expected_d;
        case (state_q)
          IDLE: begin
            state_q <= ACQUIRE;
            run_q   <= 4'd0;
          end
          ACQUIRE: begin
            if (match) begin
              run_q <= run_d;
              if (run_d == C_LOCK_LEN) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                miss_q   <= 1'b0;
              end
            end else begin
              run_q <= 4'd0;
            end
          end
          LOCKED: begin
            if (!clear) smp_cnt_q <= smp_cnt_d;
            if (match) begin
              miss_q <= 1'b0;
            end else begin
              error_q <= 1'b1;
              if (!clear) err_cnt_q <= err_cnt_d;
              if (miss_q) begin
                state_q  <= ACQUIRE;
                locked_q <= 1'b0;
                run_q    <= 4'd0;
                miss_q   <= 1'b0;
              end else begin
                miss_q <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign locked       = locked_q;
  assign error        = error_q;
  assign err_count    = err_cnt_q;
  assign sample_count = smp_cnt_q;
  assign expected     = expected_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_4_checker.sv
// tb_counter_4_checker: randomized and directed bench against a behavioural checker model.
`default_nettype none

module tb_counter_4_checker;

  localparam int LOCK_LEN = 3;
  localparam int ERRMAX   = 255;
  localparam int CNTMAX   = 65535;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  y = 4'd0;
  logic        clear = 1'b0;
  logic        locked, error;
  logic [7:0]  err_count;
  logic [15:0] sample_count;
  logic [3:0]  expected;
  logic [29:0] dut_v;

  int ntests = 0;
  int nfail  = 0;

  // model: 0=idle 1=acquire 2=locked
  int         mst, mrun, merr, msmp;
  bit         mmiss, merror;
  logic [3:0] mexp;

  counter_4_checker #(.WIDTH(4), .ERR_W(8), .CNT_W(16), .LOCK_LEN(LOCK_LEN)) dut (
    .clk(clk), .reset(reset), .en(en), .y(y), .clear(clear),
    .locked(locked), .error(error), .err_count(err_count),
    .sample_count(sample_count), .expected(expected)
  );

  assign dut_v = {locked, error, err_count, sample_count, expected};

  always #5 clk = ~clk;

  function automatic logic [29:0] mv();
    logic [7:0]  e8;
    logic [15:0] s16;
    e8  = merr[7:0];
    s16 = msmp[15:0];
    return {(mst == 2), merror, e8, s16, mexp};
  endfunction

  task automatic model_reset();
    mst = 0; mrun = 0; merr = 0; msmp = 0; mmiss = 0; merror = 0; mexp = 4'd0;
  endtask

  task automatic model_step(input bit e, input logic [3:0] yv, input bit c);
    bit ok;
    merror = 0;
    if (c) begin merr = 0; msmp = 0; end
    if (e) begin
      ok = (yv === mexp);
      case (mst)
        0: begin mst = 1; mrun = 0; end
        1: if (ok) begin
             mrun++;
             if (mrun == LOCK_LEN) begin mst = 2; mmiss = 0; end
           end else mrun = 0;
        default: begin
          if (!c && msmp < CNTMAX) msmp++;
          if (ok) mmiss = 0;
          else begin
            merror = 1;
            if (!c && merr < ERRMAX) merr++;
            if (mmiss) begin mst = 1; mrun = 0; mmiss = 0; end
            else mmiss = 1;
          end
        end
      endcase
      mexp = (yv + 4'd1) % 16;
    end
  endtask

  task automatic cyc(input bit e, input logic [3:0] yv, input bit c);
    @(negedge clk);
    en = e; y = yv; clear = c;
    @(posedge clk);
    model_step(e, yv, c);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    ntests++;
    if (dut_v !== 30'd0) begin nfail++; $display("FAIL reset_state: got %h want %h", dut_v, 30'd0); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_acquire();
    logic [3:0] s [5] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    for (int i = 0; i < 5; i++) begin
      cyc(1, s[i], 0);
      ntests++;
      if (dut_v !== mv()) begin nfail++; $display("FAIL acquire[%0d]: got %h want %h", i, dut_v, mv()); end
      ntests++;
      if (locked !== (i >= 3)) begin nfail++; $display("FAIL acquire_lock[%0d]: got %b want %b", i, locked, (i >= 3)); end
    end
    ntests++;
    if ({expected, sample_count, err_count} !== {4'd10, 16'd1, 8'd0}) begin
      nfail++; $display("FAIL acquire_end: got exp=%0d smp=%0d err=%0d want 10 1 0", expected, sample_count, err_count);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] s [9] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
    for (int i = 0; i < 9; i++) begin
      cyc(1, s[i], 0);
      ntests++;
      if (dut_v !== mv() || error !== 1'b0) begin nfail++; $display("FAIL wrap[%0d]: got %h want %h", i, dut_v, mv()); end
    end
    ntests++;
    if (expected !== 4'd3) begin nfail++; $display("FAIL wrap_end: got %0d want 3", expected); end
  endtask

  task automatic test_single_miss();
    logic [3:0] s [6] = '{4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11};
    for (int i = 0; i < 6; i++) begin
      cyc(1, s[i], 0);
      ntests++;
      if (dut_v !== mv() || error !== (i == 3)) begin nfail++; $display("FAIL single_miss[%0d]: got %h want %h", i, dut_v, mv()); end
    end
    ntests++;
    if ({locked, err_count, expected} !== {1'b1, 8'd1, 4'd12}) begin
      nfail++; $display("FAIL single_miss_end: got lk=%b err=%0d exp=%0d want 1 1 12", locked, err_count, expected);
    end
  endtask

  task automatic test_lock_loss();
    logic [3:0] s [7] = '{4'd4, 4'd5, 4'd9, 4'd3, 4'd4, 4'd5, 4'd6};
    cyc(0, 4'd0, 1);
    while (mexp != 4'd4) cyc(1, mexp, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(1, s[i], 0);
      ntests++;
      if (dut_v !== mv()) begin nfail++; $display("FAIL lock_loss[%0d]: got %h want %h", i, dut_v, mv()); end
      if (i == 3) begin
        ntests++;
        if ({locked, error, err_count} !== {1'b0, 1'b1, 8'd2}) begin
          nfail++; $display("FAIL lock_loss_drop: got lk=%b er=%b err=%0d want 0 1 2", locked, error, err_count);
        end
      end
    end
    ntests++;
    if (locked !== 1'b1) begin nfail++; $display("FAIL lock_loss_relock: got %b want 1", locked); end
  endtask

  task automatic test_saturate_clear();
    while (merr < ERRMAX) begin
      cyc(1, mexp + 4'd5, 0);
      cyc(1, mexp, 0);
      ntests++;
      if (dut_v !== mv()) begin nfail++; $display("FAIL sat_build: got %h want %h", dut_v, mv()); end
    end
    cyc(1, mexp + 4'd7, 0);
    ntests++;
    if ({error, err_count, locked} !== {1'b1, 8'd255, 1'b1}) begin
      nfail++; $display("FAIL sat_hold: got er=%b err=%0d lk=%b want 1 255 1", error, err_count, locked);
    end
    cyc(1, mexp, 1);
    ntests++;
    if ({err_count, sample_count, locked, error} !== {8'd0, 16'd0, 1'b1, 1'b0}) begin
      nfail++; $display("FAIL sat_clear: got err=%0d smp=%0d lk=%b er=%b want 0 0 1 0", err_count, sample_count, locked, error);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] s [4] = '{4'd7, 4'd8, 4'd9, 4'd10};
    cyc(1, mexp, 0);
    cyc(1, mexp + 4'd2, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    ntests++;
    if (dut_v !== 30'd0) begin nfail++; $display("FAIL async_reset: got %h want 0", dut_v); end
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1, s[i], 0);
      ntests++;
      if (dut_v !== mv() || locked !== (i == 3)) begin nfail++; $display("FAIL post_reset[%0d]: got %h want %h", i, dut_v, mv()); end
    end
  endtask

  task automatic test_random();
    bit e, c;
    logic [3:0] v;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom % 4) != 0;
      c = ($urandom % 32) == 0;
      v = (($urandom % 8) == 0) ? 4'($urandom) : mexp;
      cyc(e, v, c);
      ntests++;
      if (dut_v !== mv()) begin nfail++; $display("FAIL random[%0d]: got %h want %h", i, dut_v, mv()); end
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_wrap();
    test_single_miss();
    test_lock_loss();
    test_saturate_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

`default_nettype wire
